booth_seq_multiplier: RTL



---
 rtl/booth_seq_multiplier.sv | 124 ++++++++++++
 1 files changed

// File: rtl/booth_seq_multiplier.sv
// Sequential radix-2 Booth multiplier: one Booth step per clock, WIDTH+1 steps per product.
// Signed or unsigned operands are selected per operation; start/busy/done handshake.
module booth_seq_multiplier #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 is_signed,
    input  logic [WIDTH-1:0]     ina,
    input  logic [WIDTH-1:0]     inb,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   out
);

    localparam int              CW        = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]   LAST_STEP = CW'(WIDTH);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]           state_q,  state_d;
    logic [CW-1:0]        cnt_q,    cnt_d;
    logic                 done_q,   done_d;
    logic [2*WIDTH-1:0]   out_q,    out_d;
    logic [WIDTH+1:0]     acc_q,    acc_d;
    logic [WIDTH:0]       mul_q,    mul_d;
    logic                 qm1_q,    qm1_d;
    logic [WIDTH:0]       mcand_q,  mcand_d;

    logic [WIDTH:0]       ext_a;
    logic [WIDTH:0]       ext_b;
    logic [WIDTH+1:0]     mcand_wide;
    logic [WIDTH+1:0]     acc_sum;
    logic [WIDTH+1:0]     acc_shift;
    logic [WIDTH:0]       mul_shift;
    logic [2*WIDTH+2:0]   product;

    // Both operands become (WIDTH+1)-bit signed values, so one signed Booth
    // datapath covers the unsigned mode as well.
    assign ext_a = {is_signed & ina[WIDTH-1], ina};
    assign ext_b = {is_signed & inb[WIDTH-1], inb};

    assign mcand_wide = {mcand_q[WIDTH], mcand_q};

    always_comb begin
        case ({mul_q[0], qm1_q})
            2'b01:   acc_sum = acc_q + mcand_wide;
            2'b10:   acc_sum = acc_q - mcand_wide;
            default: acc_sum = acc_q;
        endcase
    end

    // Arithmetic right shift of {acc, multiplier, q_-1} after the add/subtract.
    assign acc_shift = {acc_sum[WIDTH+1], acc_sum[WIDTH+1:1]};
    assign mul_shift = {acc_sum[0], mul_q[WIDTH:1]};
    assign product   = {acc_shift, mul_shift};

    // NOTE: every _d gets a default first, so no path through this block can infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        out_d   = out_q;
        acc_d   = acc_q;
        mul_d   = mul_q;
        qm1_d   = qm1_q;
        mcand_d = mcand_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    mcand_d = ext_a;
                    mul_d   = ext_b;
                    acc_d   = '0;
                    qm1_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                acc_d = acc_shift;
                mul_d = mul_shift;
                qm1_d = mul_q[0];
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_STEP) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    out_d   = product[2*WIDTH-1:0];
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: non-blocking assignments here so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            out_q   <= out_d;
        end
    end

    // NOTE: datapath registers are left unreset; they are always loaded on start before use.
    always_ff @(posedge clk) begin
        acc_q   <= acc_d;
        mul_q   <= mul_d;
        qm1_q   <= qm1_d;
        mcand_q <= mcand_d;
    end

    assign busy = (state_q == ST_RUN);
    assign done = done_q;
    assign out  = out_q;

endmodule
